claw_timer_counter: RTL and testbench

- Timing and attempt-count stage directly beside the claw main control FSM: consumes its En_T1, En_T2, Add, R_C and R_TR strobes, and returns Timeout1, Timeout2 and Cnt_10.
- Timer1 limits the joystick phase. Timer2 times the prize-release dwell.
- The failure counter drives the guaranteed-grip ("tight claw") after CNT_MAX failed plays.
- Also exports the remaining joystick seconds for the display stage.

---
 rtl/claw_pkg.sv | 12 +
 rtl/claw_timer_counter_if.sv | 26 ++
 rtl/claw_sec_timer.sv | 45 ++++
 rtl/claw_timer_counter.sv | 86 ++++++++
 tb/tb_claw_timer_counter.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/claw_pkg.sv
// Shared widths and default timing constants for the claw control, timer and display stages.
package claw_pkg;

  localparam int SEC_W = 6;
  localparam int CNT_W = 4;

  localparam int TICK_DIV_DEF = 50_000_000;
  localparam int T1_SEC_DEF   = 30;
  localparam int T2_SEC_DEF   = 2;
  localparam int CNT_MAX_DEF  = 10;

endpackage

// File: rtl/claw_timer_counter_if.sv
// Strobe/status bundle between the claw main control FSM and the timer/counter stage.
interface claw_timer_counter_if;
  import claw_pkg::*;

  logic             En_T1;
  logic             En_T2;
  logic             Add;
  logic             R_C;
  logic             R_TR;
  logic             Timeout1;
  logic             Timeout2;
  logic             Cnt_10;
  logic [SEC_W-1:0] Sec_left;

  // Control FSM side drives the strobes and consumes the status.
  modport master (
    output En_T1, En_T2, Add, R_C, R_TR,
    input  Timeout1, Timeout2, Cnt_10, Sec_left
  );

  modport slave (
    input  En_T1, En_T2, Add, R_C, R_TR,
    output Timeout1, Timeout2, Cnt_10, Sec_left
  );

endinterface

// File: rtl/claw_sec_timer.sv
// Whole-second down-counter with a clock prescaler, pausable enable and a sticky timeout flag.
module claw_sec_timer
  import claw_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEF,
  parameter int T_SEC    = T1_SEC_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             reload,
  output logic             timeout,
  output logic [SEC_W-1:0] rem
);

  localparam int PS_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(TICK_DIV - 1);
  localparam logic [SEC_W-1:0] REM_INIT = SEC_W'(T_SEC);

  logic [PS_W-1:0] ps;

  // Counting stops once rem reaches zero, so enable is ignored after timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ps      <= '0;
      rem     <= REM_INIT;
      timeout <= 1'b0;
    end else if (reload) begin
      ps      <= '0;
      rem     <= REM_INIT;
      timeout <= 1'b0;
    end else if (en && (rem != '0)) begin
      if (ps == PS_LAST) begin
        ps  <= '0;
        rem <= rem - SEC_W'(1);
        if (rem == SEC_W'(1)) begin
          timeout <= 1'b1;
        end
      end else begin
        ps <= ps + PS_W'(1);
      end
    end
  end

endmodule

// File: rtl/claw_timer_counter.sv
// Joystick/release timers and saturating failed-play counter beside the claw main control FSM.
module claw_timer_counter
  import claw_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEF,
  parameter int T1_SEC   = T1_SEC_DEF,
  parameter int T2_SEC   = T2_SEC_DEF,
  parameter int CNT_MAX  = CNT_MAX_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  claw_timer_counter_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(CNT_MAX);

  logic             t1_timeout;
  logic             t2_timeout;
  logic [SEC_W-1:0] rem1;
  logic [SEC_W-1:0] rem2_unused;

  logic             add_d;
  logic             add_rise;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             cnt_10;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v >= CNT_LIM) ? CNT_LIM : v + CNT_W'(1);
  endfunction

  claw_sec_timer #(
    .TICK_DIV (TICK_DIV),
    .T_SEC    (T1_SEC)
  ) u_timer1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (bus.En_T1),
    .reload  (bus.R_TR),
    .timeout (t1_timeout),
    .rem     (rem1)
  );

  claw_sec_timer #(
    .TICK_DIV (TICK_DIV),
    .T_SEC    (T2_SEC)
  ) u_timer2 (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (bus.En_T2),
    .reload  (bus.R_TR),
    .timeout (t2_timeout),
    .rem     (rem2_unused)
  );

  assign add_rise = bus.Add & ~add_d;

  // Clear wins over a coincident rising edge of Add.
  always_comb begin
    cnt_nxt = cnt;
    if (!bus.R_C) begin
      cnt_nxt = '0;
    end else if (add_rise) begin
      cnt_nxt = sat_inc(cnt);
    end
  end

  // Cnt_10 is precomputed from cnt_nxt so it comes straight from a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      add_d  <= 1'b0;
      cnt    <= '0;
      cnt_10 <= 1'b0;
    end else begin
      add_d  <= bus.Add;
      cnt    <= cnt_nxt;
      cnt_10 <= (cnt_nxt == CNT_LIM);
    end
  end

  assign bus.Timeout1 = t1_timeout;
  assign bus.Timeout2 = t2_timeout;
  assign bus.Sec_left = rem1;
  assign bus.Cnt_10   = cnt_10;

endmodule

// File: tb/tb_claw_timer_counter.sv
// Directed plus randomized bench for claw_timer_counter against an elapsed-cycle reference model.
module tb_claw_timer_counter;
  import claw_pkg::*;

  localparam int TD = 4;
  localparam int T1 = 3;
  localparam int T2 = 2;
  localparam int CM = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  claw_timer_counter_if bus ();

  claw_timer_counter #(
    .TICK_DIV (TD),
    .T1_SEC   (T1),
    .T2_SEC   (T2),
    .CNT_MAX  (CM)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int   n_checks = 0;
  int   n_pass   = 0;
  // Reference: enabled cycles elapsed per timer, failed-play count, previous Add level.
  int   el1, el2, fcnt;
  logic prev_add;

  task automatic model_reset();
    el1 = 0; el2 = 0; fcnt = 0; prev_add = 1'b0;
  endtask

  task automatic model_step();
    if (!rst_n) begin
      model_reset();
    end else begin
      if (bus.R_TR) begin
        el1 = 0; el2 = 0;
      end else begin
        if (bus.En_T1 && el1 < T1 * TD) el1++;
        if (bus.En_T2 && el2 < T2 * TD) el2++;
      end
      if (!bus.R_C) fcnt = 0;
      else if (bus.Add && !prev_add && fcnt < CM) fcnt++;
      prev_add = bus.Add;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic check_all(input string ctx);
    check({ctx, " Timeout1"}, 32'(bus.Timeout1), 32'(el1 == T1 * TD));
    check({ctx, " Timeout2"}, 32'(bus.Timeout2), 32'(el2 == T2 * TD));
    check({ctx, " Sec_left"}, 32'(bus.Sec_left), 32'(T1 - el1 / TD));
    check({ctx, " Cnt_10"},   32'(bus.Cnt_10),   32'(fcnt == CM));
  endtask

  task automatic cycle(input string ctx);
    @(posedge clk);
    model_step();
    #1;
    check_all(ctx);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.En_T1 = 1'b0; bus.En_T2 = 1'b0; bus.Add = 1'b0;
    bus.R_C = 1'b1; bus.R_TR = 1'b0;
    model_reset();

    // Reset state
    cycle("reset");
    cycle("reset");
    check("reset Sec_left const", 32'(bus.Sec_left), 32'(T1));
    rst_n = 1'b1;

    // Continuous countdown of Timer1
    bus.R_TR = 1'b1;
    cycle("rtr");
    bus.R_TR = 1'b0;
    bus.En_T1 = 1'b1;
    for (int i = 1; i <= 14; i++) begin
      cycle("run1");
      if (i == 4)  check("sec at 4", 32'(bus.Sec_left), 32'd2);
      if (i == 8)  check("sec at 8", 32'(bus.Sec_left), 32'd1);
      if (i == 11) check("t1 before 12", 32'(bus.Timeout1), 32'd0);
      if (i == 12) check("t1 at 12", 32'(bus.Timeout1), 32'd1);
    end
    bus.En_T1 = 1'b0;

    // Pause keeps the partial second
    bus.R_TR = 1'b1;
    cycle("rtr2");
    bus.R_TR = 1'b0;
    bus.En_T1 = 1'b1;
    for (int i = 0; i < 6; i++) cycle("pre-pause");
    bus.En_T1 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cycle("pause");
      check("pause sec hold", 32'(bus.Sec_left), 32'd2);
    end
    bus.En_T1 = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      cycle("resume");
      if (i == 5) check("t1 resume 5", 32'(bus.Timeout1), 32'd0);
      if (i == 6) check("t1 resume 6", 32'(bus.Timeout1), 32'd1);
    end

    // Reload beats enable
    bus.R_TR = 1'b1;
    cycle("reload");
    check("reload t1", 32'(bus.Timeout1), 32'd0);
    check("reload sec", 32'(bus.Sec_left), 32'(T1));
    bus.R_TR = 1'b0;
    for (int i = 0; i < 4; i++) cycle("restart");
    check("restart sec", 32'(bus.Sec_left), 32'd2);
    bus.En_T1 = 1'b0;

    // Failure counter: four pulses, last held 5 cycles
    for (int p = 0; p < 4; p++) begin
      bus.Add = 1'b1;
      for (int h = 0; h < ((p == 3) ? 5 : 1); h++) cycle("add hi");
      bus.Add = 1'b0;
      cycle("add lo");
      cycle("add lo");
      if (p == 1) check("cnt10 after 2", 32'(bus.Cnt_10), 32'd0);
      if (p == 2) check("cnt10 after 3", 32'(bus.Cnt_10), 32'd1);
      if (p == 3) check("cnt10 sat", 32'(bus.Cnt_10), 32'd1);
    end

    // Clear wins over a coincident Add rise
    bus.R_C = 1'b0;
    bus.Add = 1'b1;
    cycle("clear");
    check("clear cnt10", 32'(bus.Cnt_10), 32'd0);
    bus.R_C = 1'b1;
    cycle("clear held add");
    check("held add ignored", 32'(bus.Cnt_10), 32'd0);
    bus.Add = 1'b0;
    cycle("idle");

    // Async reset in the middle of a Timer2 run
    bus.R_TR = 1'b1;
    cycle("rtr3");
    bus.R_TR = 1'b0;
    bus.En_T2 = 1'b1;
    cycle("t2 run");
    cycle("t2 run");
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_all("async");
    cycle("in reset");
    rst_n = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      cycle("t2 after rst");
      if (i == 7) check("t2 at 7", 32'(bus.Timeout2), 32'd0);
      if (i == 8) check("t2 at 8", 32'(bus.Timeout2), 32'd1);
    end
    bus.En_T2 = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      bus.En_T1 = ($urandom_range(3) != 0);
      bus.En_T2 = ($urandom_range(3) != 0);
      bus.Add   = ($urandom_range(2) == 0);
      bus.R_C   = ($urandom_range(15) != 0);
      bus.R_TR  = ($urandom_range(24) == 0);
      rst_n     = ($urandom_range(80) != 0);
      cycle("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
